// File: rtl/ssd_nios_entrada_imagem_pkg.sv
// Shared register map for the image input port: offsets, STATUS layout
// and IRQMASK layout, plus a helper that packs the STATUS word.
package ssd_nios_entrada_imagem_pkg;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_IRQMASK = 2'd2;
  localparam logic [1:0] REG_RSVD    = 2'd3;

  localparam int ST_COUNT_MSB = 4;
  localparam int ST_EMPTY_BIT = 5;
  localparam int ST_FULL_BIT  = 6;
  localparam int ST_OVF_BIT   = 7;

  localparam int MASK_NEMPTY_BIT = 0;
  localparam int MASK_OVF_BIT    = 1;
  localparam int MASK_W          = 2;

  function automatic logic [31:0] pack_status(input logic [4:0] count,
                                              input logic       empty,
                                              input logic       full,
                                              input logic       overflow);
    logic [31:0] r;
    r                  = '0;
    r[ST_COUNT_MSB:0]  = count;
    r[ST_EMPTY_BIT]    = empty;
    r[ST_FULL_BIT]     = full;
    r[ST_OVF_BIT]      = overflow;
    return r;
  endfunction

endpackage

// File: rtl/ssd_nios_pixel_fifo.sv
// Pixel FIFO: circular storage with wrapping pointers and a separate
// occupancy counter so full and empty are unambiguous.
module ssd_nios_pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [4:0]       count,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign empty = (count == 5'd0);
  assign full  = (count == 5'(DEPTH));

  // A full FIFO never accepts, even when a pop happens in the same cycle.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ssd_nios_entrada_imagem.sv
// Avalon-MM image input port: buffers incoming pixels in a small FIFO and
// exposes DATA / STATUS / IRQMASK registers plus a level interrupt.
module ssd_nios_entrada_imagem
  import ssd_nios_entrada_imagem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             irq
);

  logic [WIDTH-1:0]  fifo_rdata;
  logic [4:0]        fifo_count;
  logic              fifo_empty, fifo_full;
  logic              pop, wr_en, ovf_set, ovf_clr;
  logic              overflow;
  logic [MASK_W-1:0] mask;
  logic              unused_wdata;

  assign in_ready = ~fifo_full;
  assign pop      = chipselect & ~read_n & (address == REG_DATA);
  assign wr_en    = chipselect & ~write_n;
  assign ovf_set  = in_valid & fifo_full;
  assign ovf_clr  = wr_en & (address == REG_STATUS) & writedata[ST_OVF_BIT];

  assign unused_wdata = ^{writedata[31:8], writedata[6:2]};

  ssd_nios_pixel_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid & in_ready),
    .pop   (pop),
    .wdata (in_port),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Sticky overflow (set beats clear), interrupt mask, and registered irq.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
      mask     <= '0;
      irq      <= 1'b0;
    end else begin
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      if (wr_en && address == REG_IRQMASK) mask <= writedata[MASK_W-1:0];
      irq <= (mask[MASK_NEMPTY_BIT] & ~fifo_empty) | (mask[MASK_OVF_BIT] & overflow);
    end
  end

  // Zero-latency read mux; DATA shows the head without popping it here.
  always_comb begin
    readdata = '0;
    case (address)
      REG_DATA:    if (!fifo_empty) readdata[WIDTH-1:0] = fifo_rdata;
      REG_STATUS:  readdata = pack_status(fifo_count, fifo_empty, fifo_full, overflow);
      REG_IRQMASK: readdata[MASK_W-1:0] = mask;
      default:     readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_ssd_nios_entrada_imagem.sv
// Bench for the image input port: a table of register/pixel vectors with
// explicit expected readdata, a queue scoreboard of buffered pixels, and
// hand-written sequences for same-cycle push/pop, irq timing and reset.
module tb_ssd_nios_entrada_imagem;
  localparam int DEPTH = 4;
  localparam int WIDTH = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        address;
  logic              chipselect, read_n, write_n;
  logic [31:0]       writedata, readdata;
  logic [WIDTH-1:0]  in_port;
  logic              in_valid, in_ready, irq;

  always #5 clk = ~clk;

  ssd_nios_entrada_imagem #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .irq        (irq)
  );

  typedef struct {
    bit          pv;
    logic [7:0]  pix;
    bit          rd;
    bit          wr;
    logic [1:0]  a;
    logic [31:0] wd;
    bit          chk;
    logic [31:0] exp;
  } vec_t;

  vec_t            v[$];
  int              n_tests = 0;
  int              n_fail  = 0;
  logic [WIDTH-1:0] sb[$];
  bit              m_ovf, m_irq;
  logic [1:0]      m_mask;
  logic [31:0]     s_rdata;
  logic            s_rdy, s_irq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0:    return (sb.size() > 0) ? {24'd0, sb[0]} : 32'd0;
      2'd1:    return {24'd0, m_ovf, (sb.size() == DEPTH), (sb.size() == 0), 5'(sb.size())};
      2'd2:    return {30'd0, m_mask};
      default: return 32'd0;
    endcase
  endfunction

  task automatic add(input bit pv, input logic [7:0] pix, input bit rd, input bit wr,
                     input logic [1:0] a, input logic [31:0] wd, input bit chk, input logic [31:0] exp);
    vec_t e;
    e.pv = pv; e.pix = pix; e.rd = rd; e.wr = wr; e.a = a; e.wd = wd; e.chk = chk; e.exp = exp;
    v.push_back(e);
  endtask

  // One bus/pixel cycle: drive, sample at negedge against the model, advance model at posedge.
  task automatic step(input bit pv, input logic [7:0] pix, input bit rd, input bit wr,
                      input logic [1:0] a, input logic [31:0] wd);
    int         n;
    bit         ovf_old;
    logic [1:0] mask_old;
    in_valid = pv; in_port = pix; chipselect = rd | wr; read_n = !rd; write_n = !wr;
    address = a; writedata = wd;
    @(negedge clk);
    s_rdata = readdata; s_rdy = in_ready; s_irq = irq;
    check("in_ready", {31'd0, s_rdy}, {31'd0, (sb.size() < DEPTH)});
    check("irq", {31'd0, s_irq}, {31'd0, m_irq});
    check("readdata", s_rdata, model_rd(a));
    n = sb.size(); ovf_old = m_ovf; mask_old = m_mask;
    m_irq = (mask_old[0] && n > 0) || (mask_old[1] && ovf_old);
    if (rd && a == 2'd0 && n > 0) void'(sb.pop_front());
    if (pv && n < DEPTH) sb.push_back(pix);
    if (pv && n == DEPTH) m_ovf = 1'b1;
    else if (wr && a == 2'd1 && wd[7]) m_ovf = 1'b0;
    if (wr && a == 2'd2) m_mask = wd[1:0];
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_port = '0; chipselect = 1'b0;
    read_n = 1'b1; write_n = 1'b1; address = 2'd0; writedata = '0;
    m_ovf = 1'b0; m_irq = 1'b0; m_mask = 2'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Basic push/read, empty read, ignored writes, overflow, mask, reserved register.
    add(0, 8'h00, 1, 0, 2'd1, 32'h0, 1, 32'h20);
    add(0, 8'h00, 1, 0, 2'd0, 32'h0, 1, 32'h00);
    add(1, 8'h11, 0, 0, 2'd0, 32'h0, 0, 32'h0);
    add(1, 8'h22, 0, 0, 2'd0, 32'h0, 0, 32'h0);
    add(1, 8'h33, 0, 0, 2'd0, 32'h0, 0, 32'h0);
    add(0, 8'h00, 1, 0, 2'd1, 32'h0, 1, 32'h03);
    add(0, 8'h00, 1, 0, 2'd0, 32'h0, 1, 32'h11);
    add(0, 8'h00, 1, 0, 2'd0, 32'h0, 1, 32'h22);
    add(0, 8'h00, 1, 0, 2'd0, 32'h0, 1, 32'h33);
    add(0, 8'h00, 1, 0, 2'd1, 32'h0, 1, 32'h20);
    add(0, 8'h00, 0, 1, 2'd0, 32'h55, 0, 32'h0);
    add(0, 8'h00, 1, 0, 2'd1, 32'h0, 1, 32'h20);
    add(0, 8'h00, 1, 0, 2'd0, 32'h0, 1, 32'h00);
    for (int i = 0; i < 5; i++) add(1, 8'hA0 + 8'(i), 0, 0, 2'd0, 32'h0, 0, 32'h0);
    add(0, 8'h00, 1, 0, 2'd1, 32'h0, 1, 32'hC4);
    for (int i = 0; i < 4; i++) add(0, 8'h00, 1, 0, 2'd0, 32'h0, 1, 32'hA0 + i);
    add(0, 8'h00, 1, 0, 2'd1, 32'h0, 1, 32'hA0);
    add(0, 8'h00, 0, 1, 2'd1, 32'h80, 0, 32'h0);
    add(0, 8'h00, 1, 0, 2'd1, 32'h0, 1, 32'h20);
    add(0, 8'h00, 0, 1, 2'd2, 32'hFFFF_FFFF, 0, 32'h0);
    add(0, 8'h00, 1, 0, 2'd2, 32'h0, 1, 32'h03);
    add(0, 8'h00, 0, 1, 2'd3, 32'h1234_5678, 0, 32'h0);
    add(0, 8'h00, 1, 0, 2'd3, 32'h0, 1, 32'h00);
    add(0, 8'h00, 0, 1, 2'd2, 32'h0, 0, 32'h0);
    add(0, 8'h00, 1, 0, 2'd2, 32'h0, 1, 32'h00);

    for (int i = 0; i < v.size(); i++) begin
      step(v[i].pv, v[i].pix, v[i].rd, v[i].wr, v[i].a, v[i].wd);
      if (v[i].chk) check($sformatf("vec%0d", i), s_rdata, v[i].exp);
    end

    // Same-cycle push and pop with two entries buffered.
    step(1, 8'h01, 0, 0, 2'd0, 32'h0);
    step(1, 8'h02, 0, 0, 2'd0, 32'h0);
    step(1, 8'h55, 1, 0, 2'd0, 32'h0);
    check("pushpop_head", s_rdata, 32'h01);
    step(0, 8'h00, 1, 0, 2'd1, 32'h0);
    check("pushpop_count", s_rdata, 32'h02);
    step(0, 8'h00, 1, 0, 2'd0, 32'h0);
    check("pushpop_rd2", s_rdata, 32'h02);
    step(0, 8'h00, 1, 0, 2'd0, 32'h0);
    check("pushpop_rd55", s_rdata, 32'h55);

    // Nonempty interrupt rises after a push and falls after the pop.
    step(0, 8'h00, 0, 1, 2'd2, 32'h1);
    step(1, 8'h7E, 0, 0, 2'd0, 32'h0);
    check("irq_ne_pre", {31'd0, s_irq}, 32'd0);
    idle();
    idle();
    check("irq_ne_rise", {31'd0, s_irq}, 32'd1);
    step(0, 8'h00, 1, 0, 2'd0, 32'h0);
    check("irq_ne_pop", s_rdata, 32'h7E);
    idle();
    idle();
    check("irq_ne_fall", {31'd0, s_irq}, 32'd0);

    // Overflow interrupt, clear, and clear losing to a coincident drop.
    step(0, 8'h00, 0, 1, 2'd2, 32'h2);
    for (int i = 0; i < 5; i++) step(1, 8'hB0 + 8'(i), 0, 0, 2'd0, 32'h0);
    idle();
    idle();
    check("irq_ovf_rise", {31'd0, s_irq}, 32'd1);
    step(0, 8'h00, 0, 1, 2'd1, 32'h80);
    idle();
    idle();
    check("irq_ovf_fall", {31'd0, s_irq}, 32'd0);
    step(0, 8'h00, 1, 0, 2'd1, 32'h0);
    check("ovf_cleared", s_rdata, 32'h44);
    step(1, 8'hC0, 0, 1, 2'd1, 32'h80);
    step(0, 8'h00, 1, 0, 2'd1, 32'h0);
    check("ovf_set_wins", s_rdata, 32'hC4);
    for (int i = 0; i < 4; i++) begin
      step(0, 8'h00, 1, 0, 2'd0, 32'h0);
      check("ovf_drain", s_rdata, 32'hB0 + i);
    end

    // Reset mid-stream with a push and a mask write pending.
    step(0, 8'h00, 0, 1, 2'd2, 32'h3);
    for (int i = 0; i < 3; i++) step(1, 8'hD0 + 8'(i), 0, 0, 2'd0, 32'h0);
    idle();
    in_valid = 1'b1; in_port = 8'hEE; chipselect = 1'b1; write_n = 1'b0;
    read_n = 1'b1; address = 2'd2; writedata = 32'h3; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete(); m_ovf = 1'b0; m_mask = 2'd0; m_irq = 1'b0;
    step(0, 8'h00, 1, 0, 2'd1, 32'h0);
    check("rst_status", s_rdata, 32'h20);
    check("rst_ready", {31'd0, s_rdy}, 32'd1);
    check("rst_irq", {31'd0, s_irq}, 32'd0);
    step(0, 8'h00, 1, 0, 2'd2, 32'h0);
    check("rst_mask", s_rdata, 32'h0);
    step(0, 8'h00, 1, 0, 2'd0, 32'h0);
    check("rst_data", s_rdata, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
